// File: rtl/pattern_seq_analyzer_if.sv
// Bundles the stimulus-control and analyzer signals of pattern_seq_analyzer.
// Combinational wiring only, no added latency.
// No backpressure: the generator is free-running once triggered.
interface pattern_seq_analyzer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] seed;
    logic [1:0]       mode;
    logic [WIDTH-1:0] trigger;
    logic             continuous;
    logic             abort;
    logic             enable_analyzer;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] cmp_mask;
    logic             count_clr;
    logic [WIDTH-1:0] generated_patterns;
    logic             gen_valid;
    logic             busy;
    logic             burst_done;
    logic             match_detected;
    logic [CNT_W-1:0] match_count;

    modport master (
        output seed, mode, trigger, continuous, abort,
        output enable_analyzer, sample, expected, cmp_mask, count_clr,
        input  generated_patterns, gen_valid, busy, burst_done,
        input  match_detected, match_count
    );

    modport slave (
        input  seed, mode, trigger, continuous, abort,
        input  enable_analyzer, sample, expected, cmp_mask, count_clr,
        output generated_patterns, gen_valid, busy, burst_done,
        output match_detected, match_count
    );
endinterface

// File: rtl/pattern_seq_analyzer.sv
// Triggered DEPTH-step pattern burst generator plus masked compare analyzer with saturating count.
// Latency: first pattern one cycle after trigger; match flag/count one cycle after sample.
// No backpressure: bursts run to completion unless aborted. Mode 11 is LFSR when PATTERN_GEN_LFSR_EN is defined, else complement.
module pattern_seq_analyzer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
`ifdef PATTERN_GEN_LFSR_EN
    ,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
`endif
) (
    input logic                  clk,
    input logic                  reset,
    pattern_seq_analyzer_if.slave bus
);
    localparam int STEP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DEPTH - 1);

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_CPL    = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] pattern;
    logic [1:0]       cap_mode;
    logic [STEP_W-1:0] step;
    logic             burst_done_q;
    logic             match_q;
    logic [CNT_W-1:0] count_q;

    logic start;
    logic last_step;
    logic finish;
    logic hit;

    function automatic logic [WIDTH-1:0] load_pattern(input logic [WIDTH-1:0] s,
                                                      input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = s;
`ifdef PATTERN_GEN_LFSR_EN
        // An all-zero LFSR state would never leave zero.
        if (m == MODE_CPL && s == '0) begin
            r = WIDTH'(1);
        end
`else
        if (m == MODE_CPL) begin
            r = s;
        end
`endif
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] p,
                                                 input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SHIFT:  r = {p[WIDTH-2:0], 1'b0};
            MODE_ROTATE: r = {p[WIDTH-2:0], p[WIDTH-1]};
            MODE_HOLD:   r = p;
`ifdef PATTERN_GEN_LFSR_EN
            default:     r = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
`else
            default:     r = ~p;
`endif
        endcase
        return r;
    endfunction

    assign start     = (state == ST_IDLE) && (bus.trigger != '0) && !bus.abort;
    assign last_step = (step == LAST_STEP);
    assign finish    = (state == ST_RUN) && !bus.abort && last_step;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    next_state = ST_IDLE;
                end else if (last_step && !bus.continuous) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.generated_patterns = '0;
        bus.gen_valid          = 1'b0;
        bus.busy               = 1'b0;
        if (state == ST_RUN) begin
            bus.generated_patterns = pattern;
            bus.gen_valid          = 1'b1;
            bus.busy               = 1'b1;
        end
    end

    // Burst datapath: continuous re-arm samples the live seed/mode at the wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern      <= '0;
            cap_mode     <= MODE_SHIFT;
            step         <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= finish;
            if (start) begin
                pattern  <= load_pattern(bus.seed, bus.mode);
                cap_mode <= bus.mode;
                step     <= '0;
            end else if (state == ST_RUN) begin
                if (bus.abort) begin
                    pattern <= '0;
                    step    <= '0;
                end else if (last_step) begin
                    step <= '0;
                    if (bus.continuous) begin
                        pattern  <= load_pattern(bus.seed, bus.mode);
                        cap_mode <= bus.mode;
                    end else begin
                        pattern <= '0;
                    end
                end else begin
                    pattern <= advance(pattern, cap_mode);
                    step    <= step + STEP_W'(1);
                end
            end
        end
    end

    assign hit = bus.enable_analyzer && (bus.cmp_mask != '0) &&
                 (((bus.sample ^ bus.expected) & bus.cmp_mask) == '0);

    // Analyzer; clear wins over a same-cycle hit, count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            match_q <= hit;
            if (bus.count_clr) begin
                count_q <= '0;
            end else if (hit && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.burst_done     = burst_done_q;
    assign bus.match_detected = match_q;
    assign bus.match_count    = count_q;

endmodule

// File: doc/pattern_seq_analyzer.md
Name: pattern_seq_analyzer

Overview:
Parametrised successor to the 3-bit pattern generator/analyzer. A triggered burst engine emits a WIDTH-bit pattern sequence of DEPTH steps, evolved per step by a selectable mode (shift, rotate, hold, complement/LFSR), with optional continuous re-arm and abort. An independent masked analyzer compares observed data against an expected word and keeps a saturating match count. Sits between stimulus control and the DUT pins in the test-pattern path.

Parameters:
WIDTH, 8, pattern/trigger/sample width (>=2)
DEPTH, 8, steps per burst (>=2)
CNT_W, 16, match counter width
LFSR_TAPS, 8'hB8 (WIDTH bits), Galois feedback taps; used only with PATTERN_GEN_LFSR_EN

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low
seed  in  WIDTH  pattern loaded at burst start
mode  in  2  00 shift-left zero-fill, 01 rotate-left, 10 hold, 11 complement/LFSR
trigger  in  WIDTH  any nonzero bit starts a burst from IDLE
continuous  in  1  auto-restart at end of burst
abort  in  1  terminate burst
enable_analyzer  in  1  analyzer compare enable
sample  in  WIDTH  observed data
expected  in  WIDTH  expected data
cmp_mask  in  WIDTH  1 = bit compared
count_clr  in  1  clears match_count
generated_patterns  out  WIDTH  current pattern, 0 when not RUN
gen_valid  out  1  high in RUN
busy  out  1  high in RUN
burst_done  out  1  one-cycle pulse on natural burst end
match_detected  out  1  registered match flag
match_count  out  CNT_W  saturating match count

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, pattern 0, step 0, burst_done 0, match_detected 0, match_count 0; all outputs 0. Reset mid-burst aborts with no burst_done.
- FSM IDLE/RUN. IDLE: if trigger!=0 and abort==0 at edge T, capture seed and mode; RUN from T+1 with step 0, output = seed. trigger==0 stays IDLE.
- RUN: gen_valid=busy=1, generated_patterns=pattern. Each cycle step+1 and pattern advances per captured mode. mode/seed changes mid-burst ignored; trigger ignored in RUN.
- Mode 00: p<<1, LSB 0. Mode 01: {p[WIDTH-2:0],p[WIDTH-1]}. Mode 10: p unchanged. Mode 11: see Optional Feature.
- At step==DEPTH-1: continuous==0 -> IDLE next cycle; continuous==1 -> stay RUN, reload current seed/mode, step 0. Either way burst_done=1 for exactly the following cycle.
- abort==1 in RUN: IDLE next cycle, outputs 0, no burst_done. abort beats continuous and end-of-burst on the same cycle. abort in IDLE blocks a same-cycle trigger.
- Analyzer, independent of FSM: hit = enable_analyzer & (cmp_mask!=0) & (((sample^expected)&cmp_mask)==0). match_detected <= hit (1-cycle latency). enable_analyzer==0 -> match_detected 0 next cycle, count holds.
- match_count: +1 per hit, saturates at all-ones (no wrap). count_clr has priority: count_clr and hit on the same cycle -> 0.

Optional Feature:
PATTERN_GEN_LFSR_EN. Defined: mode 11 is Galois LFSR, next = (p>>1) ^ (p[0] ? LFSR_TAPS : 0). A zero seed loads as 1 so the sequence never locks up. Undefined: mode 11 is bitwise complement ~p; LFSR_TAPS ignored; zero seed loads as 0.

Test Plan:
- Hold reset low 3 cycles with trigger=0xFF and analyzer hitting -> all outputs 0, match_count 0; first cycle after release still IDLE.
- WIDTH=8, DEPTH=4, seed=0x81, mode=00, trigger=0x01 at T -> outputs T+1..T+4 = 0x81,0x02,0x04,0x08; T+5 output 0, busy 0, burst_done 1 for that cycle only.
- Same with mode=01, continuous=1 -> 0x81,0x03,0x06,0x0C, then 0x81 at T+5 with burst_done 1; drop continuous -> ends after the next 4 steps. Repeat with abort at T+2 -> T+3 output 0, busy 0, no burst_done.
- expected=0xA5, cmp_mask=0xF0, sample=0xAF, enable=1 -> match_detected 1 next cycle, count 1. cmp_mask=0 -> no match. CNT_W=2 with 5 hits -> count 3. count_clr with a hit -> 0.
- Mode 11, seed=0x00: with macro, outputs 0x01, 0xB8, 0x5C; without macro, outputs 0x00, 0xFF, 0x00.
